// File: rtl/preg_free_list_ctrl.sv
// Physical-register free list and squash recovery sequencer for rename.
// Optional macro PREG_FREE_LIST_CHECK_EN enables sticky double-free detection.
module preg_free_list_ctrl #(
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned ARCH_REGS = 32,
    localparam int unsigned PW = $clog2(PHYS_REGS),
    localparam int unsigned AW = $clog2(ARCH_REGS),
    localparam int unsigned CW = $clog2(PHYS_REGS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alloc_req,
    input  logic [AW-1:0] alloc_dest_arch,
    output logic          alloc_gnt,
    output logic [PW-1:0] alloc_preg,
    output logic          mt_set_dest_enable,
    output logic [PW-1:0] mt_new_dest_pr_idx,
    input  logic          retire_free_valid,
    input  logic [PW-1:0] retire_free_preg,
    input  logic          squash,
    output logic          mt_restore_enable,
    output logic [AW-1:0] mt_arch_map_idx,
    input  logic [PW-1:0] mt_arch_map_preg,
    output logic          busy,
    output logic [CW-1:0] free_count,
    output logic          double_free_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESTORE = 2'd1,
        S_REBUILD = 2'd2
    } state_t;

    localparam logic [PHYS_REGS-1:0] FREE_INIT = {{(PHYS_REGS-1){1'b1}}, 1'b0};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [AW-1:0]          r_walk;
    logic [AW-1:0]          w_walk_nxt;
    logic [PHYS_REGS-1:0]   r_free;
    logic [PHYS_REGS-1:0]   w_free_nxt;
    logic [CW-1:0]          r_free_count;
    logic [CW-1:0]          w_count_nxt;
    logic                   r_busy;
    logic [PW-1:0]          w_low;
    logic                   w_dfe_set;

    // Lowest-index free register; p0 is never a candidate.
    always_comb begin
        w_low = '0;
        for (int i = int'(PHYS_REGS) - 1; i >= 1; i--) begin
            if (r_free[i]) w_low = PW'(i);
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_walk_nxt         = r_walk;
        w_free_nxt         = r_free;
        w_dfe_set          = 1'b0;
        alloc_gnt          = 1'b0;
        alloc_preg         = '0;
        mt_set_dest_enable = 1'b0;
        mt_new_dest_pr_idx = '0;
        mt_restore_enable  = 1'b0;
        mt_arch_map_idx    = '0;
        case (r_state)
            S_IDLE: begin
                // Free is applied before the grant clear so a granted bit always ends cleared.
                if (retire_free_valid && (retire_free_preg != '0)) begin
                    w_dfe_set                    = r_free[retire_free_preg];
                    w_free_nxt[retire_free_preg] = 1'b1;
                end
                if (alloc_req && !squash) begin
                    if (alloc_dest_arch == '0) begin
                        alloc_gnt = 1'b1;
                    end else if (r_free_count != '0) begin
                        alloc_gnt          = 1'b1;
                        alloc_preg         = w_low;
                        mt_set_dest_enable = 1'b1;
                        mt_new_dest_pr_idx = w_low;
                        w_free_nxt[w_low]  = 1'b0;
                    end
                end
            end
            S_RESTORE: begin
                mt_restore_enable = 1'b1;
                w_free_nxt        = FREE_INIT;
                w_walk_nxt        = '0;
                w_state_nxt       = S_REBUILD;
            end
            S_REBUILD: begin
                mt_arch_map_idx              = r_walk;
                w_free_nxt[mt_arch_map_preg] = 1'b0;
                w_walk_nxt                   = r_walk + AW'(1);
                if (r_walk == AW'(ARCH_REGS - 1)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (squash) w_state_nxt = S_RESTORE;
        w_free_nxt[0] = 1'b0;
    end

    // Popcount of the next bitmap keeps free_count exact after any rebuild.
    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < int'(PHYS_REGS); i++) begin
            w_count_nxt = w_count_nxt + CW'(w_free_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_walk       <= '0;
            r_free       <= FREE_INIT;
            r_free_count <= CW'(PHYS_REGS - 1);
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_walk       <= w_walk_nxt;
            r_free       <= w_free_nxt;
            r_free_count <= w_count_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

`ifdef PREG_FREE_LIST_CHECK_EN
    logic r_dfe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dfe <= 1'b0;
        end else if (w_dfe_set) begin
            r_dfe <= 1'b1;
        end
    end

    assign double_free_err = r_dfe;
`else
    assign double_free_err = 1'b0;
`endif

    assign busy       = r_busy;
    assign free_count = r_free_count;

endmodule

// File: doc/preg_free_list_ctrl.md
# preg_free_list_ctrl

Physical-register allocator and rename-recovery sequencer for the rename stage. It owns the free bitmap of physical registers and grants a new physical register to each dispatching instruction, driving the map table's set-dest port. It returns retired old-dest registers to the pool. On a squash, it sequences map-table restore and then rebuilds the free bitmap by walking the architectural map one entry per cycle.

## Interface
Parameters:
- PHYS_REGS, 64, number of physical registers; p0 is the hard-wired zero register.
- ARCH_REGS, 32, number of architectural registers.
- Derived widths: PW = $clog2(PHYS_REGS), AW = $clog2(ARCH_REGS), CW = $clog2(PHYS_REGS+1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- alloc_req  in  1  dispatch requests a destination physical register.
- alloc_dest_arch  in  AW  architectural destination of the requester.
- alloc_gnt  out  1  allocation granted this cycle (combinational).
- alloc_preg  out  PW  granted physical register.
- mt_set_dest_enable  out  1  map-table set-dest enable.
- mt_new_dest_pr_idx  out  PW  map-table new destination physical register.
- retire_free_valid  in  1  ROB retires an instruction whose old destination is freed.
- retire_free_preg  in  PW  physical register being freed.
- squash  in  1  one-cycle mispredict/flush pulse.
- mt_restore_enable  out  1  map-table restore strobe.
- mt_arch_map_idx  out  AW  architectural map read index.
- mt_arch_map_preg  in  PW  architectural map read data (same-cycle combinational).
- busy  out  1  recovery in progress; registered.
- free_count  out  CW  number of free physical registers; registered.
- double_free_err  out  1  sticky protocol error (see Configuration).

## Operation
- State: a PHYS_REGS-bit free bitmap, where bit 0 is always 0. The FSM has states IDLE, RESTORE and REBUILD, plus an AW-bit walk counter.
- Reset values: bitmap = all ones except bit 0; free_count = PHYS_REGS-1; state = IDLE; busy = 0; walk counter = 0; double_free_err = 0. All other outputs are 0.
- Allocation (IDLE only, squash = 0):
  - alloc_dest_arch == 0: alloc_gnt = 1, alloc_preg = 0, mt_set_dest_enable = 0, and the bitmap is unchanged.
  - alloc_dest_arch != 0 and free_count > 0: alloc_gnt = 1 and alloc_preg = the lowest-index set bit. mt_set_dest_enable = 1 and mt_new_dest_pr_idx = alloc_preg. The bit clears at posedge.
  - free_count == 0: alloc_gnt = 0 and mt_set_dest_enable = 0.
- Free: when retire_free_valid = 1 and retire_free_preg != 0, the bit is set at posedge. Freeing p0 is ignored.
- Free and alloc in the same cycle: both apply. A preg freed this cycle is not grantable until the next cycle. free_count changes by +1, -1, or 0 accordingly.
- Squash from any state: alloc_gnt is forced to 0 in the squash cycle. Next state is RESTORE; a squash arriving in RESTORE or REBUILD restarts the sequence. A retire free in the squash cycle is applied, although the subsequent rebuild supersedes it.
- RESTORE (1 cycle): mt_restore_enable = 1. The bitmap loads all ones except bit 0, and the walk counter is set to 0. The next state is REBUILD.
- REBUILD (ARCH_REGS cycles): mt_arch_map_idx = walk counter, and at each posedge bit mt_arch_map_preg is cleared. The counter increments; after index ARCH_REGS-1 the next state is IDLE. retire_free_valid is ignored in RESTORE and REBUILD because the ROB is empty after a flush.
- busy = (state != IDLE). alloc_gnt = 0 whenever busy = 1.
- free_count is recomputed each posedge from the next-state bitmap (popcount). This keeps it exact after a rebuild, including when several arch regs map to p0.

## Timing
- Grant latency: 0 cycles, since the grant is combinational from the registered bitmap. At most one grant per cycle.
- Squash at cycle T:
  - T+1: RESTORE with mt_restore_enable = 1.
  - T+2 .. T+1+ARCH_REGS: REBUILD (T+2 .. T+33 by default).
  - T+2+ARCH_REGS: IDLE, with busy = 0 and the first grant possible.
- Reset asserted mid-recovery immediately returns all state to its reset values, independent of clk.
- mt_arch_map_idx holds 0 outside REBUILD.

## Configuration
- PREG_FREE_LIST_CHECK_EN
  - Defined: the block checks retire frees in IDLE. If retire_free_valid = 1 and retire_free_preg != 0 while that preg's bit is already set, double_free_err latches to 1 until reset. The bitmap and free_count are unchanged by the offending free.
  - Undefined: double_free_err is tied to 0 and no check logic is built. The free is applied normally (bit stays set, free_count unchanged).

## Test plan
- Release reset, then hold alloc_req with dest x1 for 3 cycles -> alloc_preg 1, 2, 3, mt_set_dest_enable = 1 each cycle, free_count 63 -> 60.
- Allocate 63 times -> free_count 0 and alloc_gnt = 0 on the 64th request. Then free p5 -> the next cycle grants p5.
- alloc_req with alloc_dest_arch = 0 -> alloc_gnt = 1, alloc_preg = 0, mt_set_dest_enable = 0, free_count unchanged.
- Squash with the arch map returning p3 for x1 and p0 elsewhere:
  - mt_restore_enable pulses at T+1.
  - busy is high at T+1 .. T+33.
  - mt_arch_map_idx sweeps 0..31.
  - At T+34, free_count = 62 and the first grant is p1.
- Second squash at REBUILD index 10 -> RESTORE again, full 33-cycle sequence, same final state. Asserting reset at index 20 -> immediate free_count 63, busy 0.
- With PREG_FREE_LIST_CHECK_EN, free p7 while p7 is free -> double_free_err = 1 and sticky, free_count unchanged. Without the macro, double_free_err stays 0.
